// File: rtl/sincos_pkg.sv
// Shared constants for the degree-indexed sine/cosine lookup: angle width,
// output scale and the quarter-wave magnitude table.
package sincos_pkg;

    localparam int ANGLE_W = 7;
    localparam int MAG_W   = 8;
    localparam int SCALE   = 100;
    localparam int QTR_DEG = 90;

    // Q[k] = round(100 * sin(k degrees)), k = 0..90
    localparam logic [MAG_W-1:0] QTR_TABLE [0:QTR_DEG] = '{
        8'd0,   8'd2,   8'd3,   8'd5,   8'd7,   8'd9,   8'd10,  8'd12,  8'd14,  8'd16,
        8'd17,  8'd19,  8'd21,  8'd22,  8'd24,  8'd26,  8'd28,  8'd29,  8'd31,  8'd33,
        8'd34,  8'd36,  8'd37,  8'd39,  8'd41,  8'd42,  8'd44,  8'd45,  8'd47,  8'd48,
        8'd50,  8'd52,  8'd53,  8'd54,  8'd56,  8'd57,  8'd59,  8'd60,  8'd62,  8'd63,
        8'd64,  8'd66,  8'd67,  8'd68,  8'd69,  8'd71,  8'd72,  8'd73,  8'd74,  8'd75,
        8'd77,  8'd78,  8'd79,  8'd80,  8'd81,  8'd82,  8'd83,  8'd84,  8'd85,  8'd86,
        8'd87,  8'd87,  8'd88,  8'd89,  8'd90,  8'd91,  8'd91,  8'd92,  8'd93,  8'd93,
        8'd94,  8'd95,  8'd95,  8'd96,  8'd96,  8'd97,  8'd97,  8'd97,  8'd98,  8'd98,
        8'd98,  8'd99,  8'd99,  8'd99,  8'd99,  8'd100, 8'd100, 8'd100, 8'd100, 8'd100,
        8'd100
    };

endpackage

// File: rtl/quarter_wave_rom.sv
// Combinational quarter-wave lookup: index 0..90 to unsigned sine magnitude.
// Indices above 90 are never produced by the folding logic and read as zero.
module quarter_wave_rom
    import sincos_pkg::*;
(
    input  logic [ANGLE_W-1:0] idx_i,
    output logic [MAG_W-1:0]   mag_o
);

    always_comb begin
        mag_o = '0;
        if (idx_i <= ANGLE_W'(QTR_DEG)) begin
            mag_o = QTR_TABLE[idx_i];
        end
    end

endmodule

// File: rtl/sincos_lut.sv
// Registered 100*sin/100*cos of a whole-degree angle 0..127, one result per
// cycle with single-cycle latency, built from a shared quarter-wave table.
module sincos_lut
    import sincos_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ANGLE_W-1:0]      angle_in,
    input  logic                    valid_in,
    output logic signed [OUT_W-1:0] sin_out,
    output logic signed [OUT_W-1:0] cos_out,
    output logic                    valid_out
);

    localparam logic [ANGLE_W-1:0]      QTR     = ANGLE_W'(QTR_DEG);
    localparam logic signed [OUT_W-1:0] COS_RST = OUT_W'(SCALE);

    logic                    in_q1;
    logic [ANGLE_W-1:0]      sin_idx;
    logic [ANGLE_W-1:0]      cos_idx;
    logic [MAG_W-1:0]        sin_mag;
    logic [MAG_W-1:0]        cos_mag;
    logic signed [OUT_W-1:0] sin_val;
    logic signed [OUT_W-1:0] cos_val;

    logic signed [OUT_W-1:0] sin_q, sin_d;
    logic signed [OUT_W-1:0] cos_q, cos_d;
    logic                    vld_q, vld_d;

    // Second quadrant: sin(a) = Q[90-(a-90)], cos(a) = -Q[a-90]; stays in 7 bits.
    always_comb begin
        in_q1   = (angle_in <= QTR);
        sin_idx = in_q1 ? angle_in : (QTR - (angle_in - QTR));
        cos_idx = in_q1 ? (QTR - angle_in) : (angle_in - QTR);
    end

    quarter_wave_rom u_rom_sin (
        .idx_i (sin_idx),
        .mag_o (sin_mag)
    );

    quarter_wave_rom u_rom_cos (
        .idx_i (cos_idx),
        .mag_o (cos_mag)
    );

    always_comb begin
        sin_val = OUT_W'(sin_mag);
        cos_val = in_q1 ? OUT_W'(cos_mag) : -OUT_W'(cos_mag);
    end

    always_comb begin
        sin_d = sin_q;
        cos_d = cos_q;
        vld_d = 1'b0;
        if (valid_in) begin
            sin_d = sin_val;
            cos_d = cos_val;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sin_q <= '0;
            cos_q <= COS_RST;
            vld_q <= 1'b0;
        end else begin
            sin_q <= sin_d;
            cos_q <= cos_d;
            vld_q <= vld_d;
        end
    end

    assign sin_out   = sin_q;
    assign cos_out   = cos_q;
    assign valid_out = vld_q;

endmodule

// File: tb/tb_sincos_lut.sv
// Directed bench for sincos_lut: reset, key angles, second quadrant, hold,
// exhaustive sweep against a real-number model, and mid-stream reset.
module tb_sincos_lut;

    localparam int  OUT_W = 16;
    localparam real PI    = 3.14159265358979323846;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [6:0]              angle_in = '0;
    logic                    valid_in = 1'b0;
    logic signed [OUT_W-1:0] sin_out;
    logic signed [OUT_W-1:0] cos_out;
    logic                    valid_out;

    int n_cmp = 0;
    int n_bad = 0;

    sincos_lut #(.OUT_W(OUT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .angle_in  (angle_in),
        .valid_in  (valid_in),
        .sin_out   (sin_out),
        .cos_out   (cos_out),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    function automatic int round_away(input real v);
        if (v >= 0.0) return int'($floor(v + 0.5));
        return -int'($floor(-v + 0.5));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b1; angle_in = 7'd45;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({sin_out, cos_out, valid_out} !== {16'sd0, 16'sd100, 1'b0}) begin
                n_bad++;
                $display("FAIL reset[%0d]: got (%0d,%0d,v%0b) want (0,100,v0)",
                         i, sin_out, cos_out, valid_out);
            end
        end
        reset = 1'b0; valid_in = 1'b0;
        tick();
        n_cmp++;
        if ({sin_out, cos_out, valid_out} !== {16'sd0, 16'sd100, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_release: got (%0d,%0d,v%0b) want (0,100,v0)",
                     sin_out, cos_out, valid_out);
        end
    endtask

    task automatic test_key_angles();
        int ang [5] = '{0, 30, 45, 60, 90};
        int es  [5] = '{0, 50, 71, 87, 100};
        int ec  [5] = '{100, 87, 71, 50, 0};
        for (int i = 0; i < 5; i++) begin
            angle_in = 7'(ang[i]); valid_in = 1'b1;
            tick();
            n_cmp++;
            if ({sin_out, cos_out, valid_out} !== {16'(es[i]), 16'(ec[i]), 1'b1}) begin
                n_bad++;
                $display("FAIL key_angle %0d: got (%0d,%0d,v%0b) want (%0d,%0d,v1)",
                         ang[i], sin_out, cos_out, valid_out, es[i], ec[i]);
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_second_quadrant();
        int ang [3] = '{91, 120, 127};
        int es  [3] = '{100, 87, 80};
        int ec  [3] = '{-2, -50, -60};
        for (int i = 0; i < 3; i++) begin
            angle_in = 7'(ang[i]); valid_in = 1'b1;
            tick();
            n_cmp++;
            if ({sin_out, cos_out, valid_out} !== {16'(es[i]), 16'(ec[i]), 1'b1}) begin
                n_bad++;
                $display("FAIL quadrant2 %0d: got (%0d,%0d,v%0b) raw cos %h want (%0d,%0d,v1)",
                         ang[i], sin_out, cos_out, valid_out, cos_out, es[i], ec[i]);
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_hold();
        angle_in = 7'd60; valid_in = 1'b1;
        tick();
        n_cmp++;
        if ({sin_out, cos_out, valid_out} !== {16'sd87, 16'sd50, 1'b1}) begin
            n_bad++;
            $display("FAIL hold_load: got (%0d,%0d,v%0b) want (87,50,v1)",
                     sin_out, cos_out, valid_out);
        end
        angle_in = 7'd10; valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({sin_out, cos_out, valid_out} !== {16'sd87, 16'sd50, 1'b0}) begin
                n_bad++;
                $display("FAIL hold[%0d]: got (%0d,%0d,v%0b) want (87,50,v0)",
                         i, sin_out, cos_out, valid_out);
            end
        end
    endtask

    task automatic test_sweep();
        int es, ec;
        for (int a = 0; a < 128; a++) begin
            angle_in = 7'(a); valid_in = 1'b1;
            es = round_away(100.0 * $sin(real'(a) * PI / 180.0));
            ec = round_away(100.0 * $cos(real'(a) * PI / 180.0));
            tick();
            n_cmp++;
            if ({sin_out, cos_out, valid_out} !== {16'(es), 16'(ec), 1'b1}) begin
                n_bad++;
                $display("FAIL sweep %0d: got (%0d,%0d,v%0b) want (%0d,%0d,v1)",
                         a, sin_out, cos_out, valid_out, es, ec);
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_midstream_reset();
        int es, ec;
        for (int a = 60; a < 128; a++) begin
            angle_in = 7'(a); valid_in = 1'b1;
            if (a == 70) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                n_cmp++;
                if ({sin_out, cos_out, valid_out} !== {16'sd0, 16'sd100, 1'b0}) begin
                    n_bad++;
                    $display("FAIL midreset: got (%0d,%0d,v%0b) want (0,100,v0)",
                             sin_out, cos_out, valid_out);
                end
            end
            es = round_away(100.0 * $sin(real'(a) * PI / 180.0));
            ec = round_away(100.0 * $cos(real'(a) * PI / 180.0));
            tick();
            n_cmp++;
            if ({sin_out, cos_out, valid_out} !== {16'(es), 16'(ec), 1'b1}) begin
                n_bad++;
                $display("FAIL resume %0d: got (%0d,%0d,v%0b) want (%0d,%0d,v1)",
                         a, sin_out, cos_out, valid_out, es, ec);
            end
        end
        valid_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_key_angles();
        test_second_quadrant();
        test_hold();
        test_sweep();
        test_midstream_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sincos_lut.md
SINCOS_LUT -- requirements
Module: sincos_lut

Interface
REQ-001 Parameter: OUT_W, default 16, signed output width; legal values 8..32.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: angle_in  input  7  unsigned angle in whole degrees, 0..127.
REQ-005 Port: valid_in  input  1  angle_in is to be sampled this cycle.
REQ-006 Port: sin_out  output  OUT_W  signed, registered, 100*sin(angle).
REQ-007 Port: cos_out  output  OUT_W  signed, registered, 100*cos(angle).
REQ-008 Port: valid_out  output  1  sin_out/cos_out updated on the last edge.

Function
REQ-009 Results SHALL use a fixed scale of 100 (value 100 = 1.0), two's complement, sign-extended to OUT_W.
REQ-010 Each result SHALL equal the exact value rounded to the nearest integer, halves rounded away from zero.
REQ-011 Angles 0..90 SHALL come from a 91-entry quarter-wave table Q[k] = round(100*sin k°), with Q[0]=0 and Q[90]=100.
REQ-012 For a in 0..90: sin = Q[a], cos = Q[90-a].
REQ-013 For a in 91..127: sin = Q[180-a], cos = -Q[a-90].
REQ-014 The computation SHALL be combinational from angle_in to the output registers; there SHALL be no internal state other than those registers.
REQ-015 Latency SHALL be exactly 1 cycle: with valid_in=1 at edge N, sin_out/cos_out SHALL hold the result for that angle_in and valid_out=1 after edge N.
REQ-016 When valid_in=0 at an edge, sin_out/cos_out SHALL hold their values and valid_out SHALL be 0 after that edge.
REQ-017 Back-to-back valid_in=1 SHALL give one result per cycle, with no stalls and no back-pressure.
REQ-018 All 128 input codes SHALL be legal, with no wrap-around or error state; 127 is the maximum.
REQ-019 The magnitude of sin_out and cos_out SHALL never exceed 100.

Reset
REQ-020 While reset=1 at an edge: sin_out=0, cos_out=100 (the angle-0 result), valid_out=0. Reset SHALL take priority over valid_in.
REQ-021 If reset is asserted on the same edge as valid_in=1, that sample SHALL be discarded. The first valid result follows the first valid_in=1 edge after reset deasserts.

Structure
REQ-022 A shared package sincos_pkg SHALL hold the following:
- ANGLE_W=7
- SCALE=100
- QTR_DEG=90
- the 91-entry quarter-wave constant table
REQ-023 One sub-module, quarter_wave_rom, SHALL be instantiated twice (sine index and cosine index). It is a combinational 7-bit index to 8-bit unsigned magnitude lookup.
REQ-024 Quadrant folding, negation, sign extension and the output registers SHALL reside in sincos_lut.

Verification
REQ-025 Reset: hold reset=1 for 2 cycles with valid_in=1 and angle 45 -> sin_out=0, cos_out=100, valid_out=0.
REQ-026 Key angles, one per cycle:
- 0 -> (0,100)
- 30 -> (50,87)
- 45 -> (71,71)
- 60 -> (87,50)
- 90 -> (100,0)
Each result appears exactly 1 cycle after its sample.
REQ-027 Second quadrant:
- 91 -> (100,-2)
- 120 -> (87,-50)
- 127 -> (80,-60)
Negative values SHALL be correctly sign-extended to OUT_W.
REQ-028 Hold: apply 60 with valid_in=1, then 10 with valid_in=0 for 3 cycles -> outputs stay (87,50), valid_out goes 1 then 0.
REQ-029 Exhaustive sweep: all angles 0..127 back-to-back -> every output matches the REQ-010 rounding rule against a real-number model, with valid_out high every cycle.
REQ-030 Mid-stream reset: assert reset during the sweep at angle 70 -> the next outputs are (0,100) with valid_out=0, and the sweep resumes correctly after release.
